// File: rtl/entry_pkg.sv
// -----------------------------------------------------------------------------
// entry_pkg
// Shared definitions for the operand entry sequencer: FSM state encoding,
// button index assignments and the switch field holding the opcode.
// -----------------------------------------------------------------------------
package entry_pkg;

   // Encodings are visible on the board LEDs, so they are fixed explicitly.
   typedef enum logic [1:0] {
      GET_A   = 2'd0,
      GET_B   = 2'd1,
      GET_OP  = 2'd2,
      PRESENT = 2'd3
   } entry_state_e;

   // Positions of the keys within the buttons bus.
   localparam int ENTER_IDX = 0;
   localparam int CLEAR_IDX = 1;

   // Switch field carrying the operation select.
   localparam int OP_MSB = 9;
   localparam int OP_LSB = 8;

endpackage : entry_pkg

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronizes one raw, active-low board key and filters contact bounce. The
// debounced level follows the synchronized input only after it has disagreed
// for DEBOUNCE_CYCLES consecutive cycles; a press pulse marks each accepted
// released->pressed transition.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   raw      in   raw key level, asynchronous, 0 = pressed
//   level    out  debounced key level, 1 = released
//   press    out  one-cycle pulse on the debounced 1->0 transition
// -----------------------------------------------------------------------------
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // The flip happens on the edge that would take the count to DEBOUNCE_CYCLES,
   // so the level has then been contradicted for exactly DEBOUNCE_CYCLES cycles.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      sync1_d = raw;
      sync2_d = sync1_q;
      level_d = level_q;
      press_d = 1'b0;
      count_d = '0;   // any agreement with the current level restarts the count

      if (sync2_q != level_q) begin
         if (count_q == CNT_LAST) begin
            level_d = sync2_q;
            press_d = ~sync2_q;   // only the move to pressed is an event
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      if (!reset_n) begin
         // Synchronizer and level start as "released" so leaving reset with a
         // key already held still needs a full debounce interval.
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         press_q <= 1'b0;
         count_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         count_q <= count_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule : button_debounce

// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
// Input sequencer for the ALU datapath. ENTER walks through capturing operand
// A, operand B and the opcode/unit select from the slide switches; the finished
// command is then offered to the datapath with a valid/ready handshake. CLEAR
// aborts back to operand A entry without disturbing the captured values.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset_n   in   synchronous active-low reset
//   buttons   in   raw keys, active-low: [0]=ENTER, [1]=CLEAR
//   switches  in   raw slide switches, sampled on ENTER
//   num_a     out  captured operand A
//   num_b     out  captured operand B
//   op_sel    out  captured operation, switches[9:8]
//   unit_sel  out  captured result-mux select, switches[1:0]
//   valid     out  command complete and stable
//   ready     in   consumer accepts when valid && ready
//   state     out  current FSM state for LED display
// -----------------------------------------------------------------------------
module operand_entry #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int WIDTH           = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [1:0]       buttons,
   input  logic [9:0]       switches,
   output logic [WIDTH-1:0] num_a,
   output logic [WIDTH-1:0] num_b,
   output logic [1:0]       op_sel,
   output logic [1:0]       unit_sel,
   output logic             valid,
   input  logic             ready,
   output logic [1:0]       state
);

   import entry_pkg::*;

   logic [1:0] btn_level;
   logic [1:0] btn_press;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_enter_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (buttons[ENTER_IDX]),
      .level   (btn_level[ENTER_IDX]),
      .press   (btn_press[ENTER_IDX])
   );

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_clear_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (buttons[CLEAR_IDX]),
      .level   (btn_level[CLEAR_IDX]),
      .press   (btn_press[CLEAR_IDX])
   );

   // A press pulse is always accompanied by a pressed level on the same cycle;
   // qualifying with the level keeps the events tied to the debounced state.
   logic enter_evt;
   logic clear_evt;
   assign enter_evt = btn_press[ENTER_IDX] & ~btn_level[ENTER_IDX];
   assign clear_evt = btn_press[CLEAR_IDX] & ~btn_level[CLEAR_IDX];

   // Switches are only read at capture time, but still pass through two flops
   // so a capture never sees a metastable bit.
   logic [9:0] sw_sync1_q, sw_sync1_d;
   logic [9:0] sw_sync2_q, sw_sync2_d;

   entry_state_e     state_q,    state_d;
   logic [WIDTH-1:0] num_a_q,    num_a_d;
   logic [WIDTH-1:0] num_b_q,    num_b_d;
   logic [1:0]       op_sel_q,   op_sel_d;
   logic [1:0]       unit_sel_q, unit_sel_d;
   logic             valid_q,    valid_d;

   always_comb begin
      sw_sync1_d = switches;
      sw_sync2_d = sw_sync1_q;
      state_d    = state_q;
      num_a_d    = num_a_q;
      num_b_d    = num_b_q;
      op_sel_d   = op_sel_q;
      unit_sel_d = unit_sel_q;

      // CLEAR takes priority over ENTER so a simultaneous press captures nothing.
      if (clear_evt) begin
         state_d = GET_A;
      end else begin
         unique case (state_q)
            GET_A: begin
               if (enter_evt) begin
                  num_a_d = sw_sync2_q[WIDTH-1:0];
                  state_d = GET_B;
               end
            end
            GET_B: begin
               if (enter_evt) begin
                  num_b_d = sw_sync2_q[WIDTH-1:0];
                  state_d = GET_OP;
               end
            end
            GET_OP: begin
               if (enter_evt) begin
                  op_sel_d   = sw_sync2_q[OP_MSB:OP_LSB];
                  unit_sel_d = sw_sync2_q[1:0];
                  state_d    = PRESENT;
               end
            end
            PRESENT: begin
               // ENTER is deliberately ignored here; only the handshake leaves.
               if (valid_q && ready) begin
                  state_d = GET_A;
               end
            end
            default: state_d = GET_A;
         endcase
      end

      // Registered valid tracks the next state, so it rises the cycle after the
      // final capture and falls the cycle after the accepting edge.
      valid_d = (state_d == PRESENT);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sw_sync1_q <= '0;
         sw_sync2_q <= '0;
         state_q    <= GET_A;
         num_a_q    <= '0;
         num_b_q    <= '0;
         op_sel_q   <= '0;
         unit_sel_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         sw_sync1_q <= sw_sync1_d;
         sw_sync2_q <= sw_sync2_d;
         state_q    <= state_d;
         num_a_q    <= num_a_d;
         num_b_q    <= num_b_d;
         op_sel_q   <= op_sel_d;
         unit_sel_q <= unit_sel_d;
         valid_q    <= valid_d;
      end
   end

   assign num_a    = num_a_q;
   assign num_b    = num_b_q;
   assign op_sel   = op_sel_q;
   assign unit_sel = unit_sel_q;
   assign valid    = valid_q;
   assign state    = state_q;

endmodule : operand_entry
